// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for the instruction memory write port.
// Frame: SYNC_BYTE, count[7:0], count[15:8], then 4*count little-endian payload bytes.
// Holds the CPU (cpu_hold) while an image is being written.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// and a CSUM state that validates it before signalling done.
module imem_loader #(
    parameter int                     INS_ADDRESS = 32,
    parameter int                     INS_W       = 32,
    parameter logic [INS_ADDRESS-1:0] BASE_ADDR   = {INS_ADDRESS{1'b0}},
    parameter int                     MEM_WORDS   = 18,
    parameter logic [7:0]             SYNC_BYTE   = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic                   wr_en,
    output logic [INS_ADDRESS-1:0] wr_addr,
    output logic [INS_W-1:0]       wr_data,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   error
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_FINISH = 3'd4
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        ST_CSUM   = 3'd5
`endif
    } state_t;

    localparam logic [15:0] MAX_WORDS = 16'(MEM_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over payload bytes.
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        csum_update = acc ^ b;
    endfunction
`endif

    state_t                 state_r;
    logic [7:0]             count_lo_r;
    logic [15:0]            count_r;
    logic [15:0]            word_idx_r;
    logic [1:0]             byte_idx_r;
    logic [INS_W-1:0]       asm_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]             csum_r;
`endif

    logic                   hs_s;
    logic [15:0]            len_s;
    logic [INS_W-1:0]       word_s;
    logic                   last_word_s;
    logic [INS_ADDRESS-1:0] addr_off_s;

    // Handshake and datapath helpers derived from the current byte.
    assign hs_s        = rx_valid & rx_ready;
    assign len_s       = {rx_data, count_lo_r};
    assign word_s      = {rx_data, asm_r[INS_W-1:8]};
    assign last_word_s = (word_idx_r == (count_r - 16'd1));
    assign addr_off_s  = INS_ADDRESS'({word_idx_r, 2'b00});

    // Frame parser FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            count_lo_r <= 8'h00;
            count_r    <= 16'h0000;
            word_idx_r <= 16'h0000;
            byte_idx_r <= 2'd0;
            asm_r      <= {INS_W{1'b0}};
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r     <= 8'h00;
`endif
            rx_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= BASE_ADDR;
            wr_data    <= {INS_W{1'b0}};
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    rx_ready <= 1'b1;
                    if (hs_s && (rx_data == SYNC_BYTE)) begin
                        state_r    <= ST_LEN_LO;
                        cpu_hold   <= 1'b1;
                        error      <= 1'b0;
                        word_idx_r <= 16'h0000;
                        byte_idx_r <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r     <= 8'h00;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LEN_LO: begin
                    if (hs_s) begin
                        count_lo_r <= rx_data;
                        state_r    <= ST_LEN_HI;
                    end else begin
                        state_r <= ST_LEN_LO;
                    end
                end
                ST_LEN_HI: begin
                    if (hs_s) begin
                        count_r <= len_s;
                        if (len_s > MAX_WORDS) begin
                            error    <= 1'b1;
                            cpu_hold <= 1'b0;
                            state_r  <= ST_IDLE;
                        end else if (len_s == 16'h0000) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_r  <= ST_CSUM;
`else
                            state_r  <= ST_FINISH;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            rx_ready <= 1'b0;
`endif
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else begin
                        state_r <= ST_LEN_HI;
                    end
                end
                ST_DATA: begin
                    if (hs_s) begin
                        asm_r      <= word_s;
                        byte_idx_r <= byte_idx_r + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r     <= csum_update(csum_r, rx_data);
`endif
                        if (byte_idx_r == 2'd3) begin
                            wr_en      <= 1'b1;
                            wr_data    <= word_s;
                            wr_addr    <= BASE_ADDR + addr_off_s;
                            word_idx_r <= word_idx_r + 16'd1;
                            if (last_word_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_r  <= ST_CSUM;
`else
                                state_r  <= ST_FINISH;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
                                rx_ready <= 1'b0;
`endif
                            end else begin
                                state_r <= ST_DATA;
                            end
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (hs_s) begin
                        cpu_hold <= 1'b0;
                        if (rx_data == csum_r) begin
                            state_r  <= ST_FINISH;
                            done     <= 1'b1;
                            rx_ready <= 1'b0;
                        end else begin
                            error   <= 1'b1;
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_CSUM;
                    end
                end
`endif
                ST_FINISH: begin
                    rx_ready <= 1'b1;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    rx_ready <= 1'b1;
                    cpu_hold <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames from the test plan plus
// randomized gapped images checked against a frame-level reference model.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    logic [63:0] got_q[$];

    imem_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect memory writes and done pulses as they appear.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) got_q.push_back({wr_addr, wr_data});
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Offer one byte after a random idle gap; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int  gap;
        int  w;
        bit  acc;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        acc = 1'b0;
        w   = 0;
        while (!acc && w < 16) begin
            acc = rx_ready;
            @(posedge clk); #1;
            w++;
        end
        rx_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            $display("FAIL hs_timeout: byte %0h not accepted within %0d cycles", b, w);
        end
    endtask

    // Send a full frame around the given payload; the model derives expected writes.
    task automatic send_frame(input logic [7:0] pay[$], input int max_gap, input bit bad_csum);
        logic [7:0]  frm[$];
        logic [63:0] exp_q[$];
        logic [31:0] word;
        logic [7:0]  x;
        logic [15:0] n16;
        int n, last, d0;
        bit bad, is_wr;
        n   = pay.size() / 4;
        n16 = 16'(n);
        x   = 8'h00;
        foreach (pay[i]) x = x ^ pay[i];
        for (int w = 0; w < n; w++) begin
            word = 32'h0;
            for (int k = 0; k < 4; k++) word = word + (32'(pay[4*w+k]) << (8*k));
            exp_q.push_back({BASE + 32'(4*w), word});
        end
        frm.push_back(SYNC);
        frm.push_back(n16[7:0]);
        frm.push_back(n16[15:8]);
        foreach (pay[i]) frm.push_back(pay[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        bad = bad_csum;
        frm.push_back(bad ? (x ^ 8'hB3) : x);
`else
        bad = 1'b0;
`endif
        last = frm.size() - 1;
        got_q.delete();
        d0 = done_cnt;
        for (int i = 0; i <= last; i++) begin
            send_byte(frm[i], max_gap);
            is_wr = (i >= 3) && (i < 3 + 4*n) && (((i - 3) % 4) == 3);
            check("wr_en", 64'(wr_en), 64'(is_wr));
            if (is_wr) begin
                check("wr_addr", 64'(wr_addr), 64'(exp_q[(i-3)/4][63:32]));
                check("wr_data", 64'(wr_data), 64'(exp_q[(i-3)/4][31:0]));
            end
            check("done", 64'(done), 64'((i == last) && !bad));
            check("cpu_hold", 64'(cpu_hold), 64'(i != last));
            check("error", 64'(error), 64'((i == last) && bad));
        end
        check("rx_ready_end", 64'(rx_ready), 64'(bad));
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'(0));
        check("done_count", 64'(done_cnt - d0), 64'(bad ? 0 : 1));
        check("n_writes", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("write_entry", got_q[i], exp_q[i]);
    endtask

    task automatic check_reset_values();
        check("rst_rx_ready", 64'(rx_ready), 64'(0));
        check("rst_wr_en", 64'(wr_en), 64'(0));
        check("rst_wr_addr", 64'(wr_addr), 64'(BASE));
        check("rst_wr_data", 64'(wr_data), 64'(0));
        check("rst_cpu_hold", 64'(cpu_hold), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] b;
        int n;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        check_reset_values();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rx_ready_after_reset", 64'(rx_ready), 64'(1));

        // Two-word directed image.
        q = '{8'h93, 8'h00, 8'h20, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
        send_frame(q, 0, 1'b0);

        // Leading junk discarded, then an empty image.
        send_byte(8'h11, 0);
        check("junk_hold", 64'(cpu_hold), 64'(0));
        send_byte(8'h22, 0);
        check("junk_hold2", 64'(cpu_hold), 64'(0));
        q.delete();
        send_frame(q, 0, 1'b0);

        // Oversize count rejected; next sync clears the error.
        got_q.delete();
        send_byte(SYNC, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        check("ovs_error", 64'(error), 64'(1));
        check("ovs_hold", 64'(cpu_hold), 64'(0));
        check("ovs_done", 64'(done), 64'(0));
        repeat (4) @(posedge clk);
        #1;
        check("ovs_no_writes", 64'(got_q.size()), 64'(0));
        check("ovs_sticky", 64'(error), 64'(1));
        send_byte(SYNC, 0);
        check("resync_error", 64'(error), 64'(0));
        check("resync_hold", 64'(cpu_hold), 64'(1));
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        check("resync_done", 64'(done), 64'(1));
        @(posedge clk); #1;

        // Randomized gapped images; sync value embedded as payload data.
        for (int f = 0; f < 6; f++) begin
            n = (f == 0) ? 3 : ((f == 1) ? 18 : int'($urandom_range(1, 18)));
            q.delete();
            for (int i = 0; i < 4*n; i++) q.push_back(8'($urandom));
            if (f == 0) begin
                q[0] = SYNC;
                q[6] = SYNC;
            end
            send_frame(q, (f % 2 == 0) ? 3 : 0, 1'b0);
        end

        // Reset in the middle of word 1.
        got_q.delete();
        send_byte(SYNC, 0);
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom) | 8'h01;
            send_byte(b, 0);
        end
        rst_n = 1'b0;
        #1;
        check_reset_values();
        check("midrst_writes", 64'(got_q.size()), 64'(1));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", 64'(rx_ready), 64'(1));
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
        send_frame(q, 1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum good and bad on a one-word image.
        q = '{8'h93, 8'h00, 8'h20, 8'h00};
        send_frame(q, 0, 1'b0);
        send_frame(q, 0, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
